// File: rtl/led_pkg.sv
// Shared definitions for the LED bank controller.
//   - Register address map for the 2-bit peripheral address.
//   - Reset defaults for the DUTY and PERIOD registers.
package led_pkg;

  localparam logic [1:0] ADDR_VALUE    = 2'd0;
  localparam logic [1:0] ADDR_BLINK_EN = 2'd1;
  localparam logic [1:0] ADDR_DUTY     = 2'd2;
  localparam logic [1:0] ADDR_PERIOD   = 2'd3;

  localparam int unsigned DEFAULT_PERIOD = 0;

  // Full brightness: all ones across the duty field.
  function automatic logic [7:0] default_duty(input int unsigned bits);
    logic [8:0] ones;
    ones = (9'd1 << bits) - 9'd1;
    return ones[7:0];
  endfunction

endpackage

// File: rtl/led_bank_ctrl_if.sv
// Simple peripheral write bus with readback.
//   in    : 16-bit write data
//   addr  : 2-bit register select
//   we    : write strobe
//   rdata : 16-bit combinational readback of the selected register
interface led_bank_ctrl_if;

  logic [15:0] in;
  logic [1:0]  addr;
  logic        we;
  logic [15:0] rdata;

  modport master (
    output in,
    output addr,
    output we,
    input  rdata
  );

  modport slave (
    input  in,
    input  addr,
    input  we,
    output rdata
  );

endinterface

// File: rtl/led_pwm_timebase.sv
// Timebase for the LED bank: clock prescaler, PWM counter and blink counter/phase.
//   clk, reset  : clock and synchronous active-high reset
//   duty        : PWM duty (0 = off, all ones = always on)
//   period      : blink period, in PWM periods minus one
//   pwm_on      : current PWM gate
//   blink_phase : blink phase, toggles after (period + 1) PWM wraps
module led_pwm_timebase #(
  parameter int unsigned PWM_BITS    = 4,
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PWM_BITS-1:0]    duty,
  input  logic [PERIOD_BITS-1:0] period,
  output logic                   pwm_on,
  output logic                   blink_phase
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]        ps_cnt_q;
  logic [PWM_BITS-1:0]    pwm_cnt_q;
  logic [PERIOD_BITS-1:0] blink_cnt_q;
  logic                   blink_phase_q;
  logic                   tick;
  logic                   pwm_wrap;

  // With PRESCALE=1 the counter sits at 0 == PS_LAST, so tick is constant high.
  assign tick     = (ps_cnt_q == PS_LAST);
  assign pwm_wrap = tick && (pwm_cnt_q == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt_q      <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      ps_cnt_q <= tick ? '0 : ps_cnt_q + 1'b1;
      if (tick) begin
        pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
      if (pwm_wrap) begin
        // >= so a PERIOD lowered below the running count takes effect at once.
        if (blink_cnt_q >= period) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (duty == '0) begin
      pwm_on = 1'b0;
    end else if (duty == '1) begin
      pwm_on = 1'b1;
    end else begin
      pwm_on = (pwm_cnt_q < duty);
    end
  end

  assign blink_phase = blink_phase_q;

endmodule

// File: rtl/led_bank_ctrl.sv
// LED bank controller: bus-writable on/off pattern, per-LED blink enable,
// global PWM brightness and programmable blink period.
//   clk, reset : clock and synchronous active-high reset
//   bus        : write bus (in/addr/we) with combinational readback (rdata)
//   Led        : registered LED drive
module led_bank_ctrl
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 8,
  parameter int unsigned PWM_BITS    = 4,
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned PERIOD_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  led_bank_ctrl_if.slave      bus,
  output logic [NUM_LEDS-1:0] Led
);

  localparam logic [PWM_BITS-1:0]    DUTY_RST   = PWM_BITS'(default_duty(PWM_BITS));
  localparam logic [PERIOD_BITS-1:0] PERIOD_RST = PERIOD_BITS'(DEFAULT_PERIOD);

  logic [NUM_LEDS-1:0]    value_q;
  logic [NUM_LEDS-1:0]    blink_en_q;
  logic [PWM_BITS-1:0]    duty_q;
  logic [PERIOD_BITS-1:0] period_q;
  logic [NUM_LEDS-1:0]    led_q;
  logic [NUM_LEDS-1:0]    led_d;
  logic [15:0]            rdata;
  logic                   pwm_on;
  logic                   blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q    <= '0;
      blink_en_q <= '0;
      duty_q     <= DUTY_RST;
      period_q   <= PERIOD_RST;
    end else if (bus.we) begin
      unique case (bus.addr)
        ADDR_VALUE:    value_q    <= bus.in[NUM_LEDS-1:0];
        ADDR_BLINK_EN: blink_en_q <= bus.in[NUM_LEDS-1:0];
        ADDR_DUTY:     duty_q     <= bus.in[PWM_BITS-1:0];
        ADDR_PERIOD:   period_q   <= bus.in[PERIOD_BITS-1:0];
        default:       ;
      endcase
    end
  end

  led_pwm_timebase #(
    .PWM_BITS    (PWM_BITS),
    .PRESCALE    (PRESCALE),
    .PERIOD_BITS (PERIOD_BITS)
  ) u_timebase (
    .clk         (clk),
    .reset       (reset),
    .duty        (duty_q),
    .period      (period_q),
    .pwm_on      (pwm_on),
    .blink_phase (blink_phase)
  );

  // Blink-enabled LEDs are gated off during the low blink phase.
  assign led_d = value_q & {NUM_LEDS{pwm_on}} & (~blink_en_q | {NUM_LEDS{blink_phase}});

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign Led = led_q;

  always_comb begin
    rdata = '0;
    unique case (bus.addr)
      ADDR_VALUE:    rdata[NUM_LEDS-1:0]    = value_q;
      ADDR_BLINK_EN: rdata[NUM_LEDS-1:0]    = blink_en_q;
      ADDR_DUTY:     rdata[PWM_BITS-1:0]    = duty_q;
      ADDR_PERIOD:   rdata[PERIOD_BITS-1:0] = period_q;
      default:       rdata                  = '0;
    endcase
  end

  assign bus.rdata = rdata;

endmodule

// File: tb/tb_led_bank_ctrl.sv
module tb_led_bank_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] Led;
  int         n_checks;
  int         n_fail;

  led_bank_ctrl_if bus ();

  led_bank_ctrl #(
    .NUM_LEDS    (8),
    .PWM_BITS    (4),
    .PRESCALE    (2),
    .PERIOD_BITS (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .Led   (Led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one write; returns 1ns after the edge that loads the register.
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.in   = d;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles until Led[0] changes; budget+1 on timeout.
  task automatic wait_bit0_change(input int budget, output int cycles);
    logic prev;
    prev   = Led[0];
    cycles = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (Led[0] !== prev) begin
        cycles = i;
        break;
      end
    end
  endtask

  logic [15:0] rd;
  int          ones;
  int          rises;
  int          bit1_low;
  int          gap;
  logic [7:0]  prev_led;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.in   = '0;
    bus.addr = '0;
    bus.we   = 1'b0;
    repeat (3) step();
    check_eq("reset_led", 32'(Led), 32'h00);
    read_reg(2'd2, rd);
    check_eq("reset_duty", 32'(rd), 32'h000F);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Plain register behaviour with defaults: 1-cycle write-to-Led delay.
    bus_write(2'd0, 16'h00A5);
    check_eq("value_edge_k", 32'(Led), 32'h00);
    step();
    check_eq("value_edge_k1", 32'(Led), 32'hA5);
    read_reg(2'd0, rd);
    check_eq("rd_value", 32'(rd), 32'h00A5);
    read_reg(2'd2, rd);
    check_eq("rd_duty_default", 32'(rd), 32'h000F);

    // DUTY=4: 8 of every 32 clk on; upper data bits dropped.
    bus_write(2'd2, 16'hAB04);
    bus_write(2'd0, 16'h00FF);
    read_reg(2'd2, rd);
    check_eq("rd_duty_masked", 32'(rd), 32'h0004);
    repeat (4) step();
    ones     = 0;
    rises    = 0;
    prev_led = Led;
    for (int i = 0; i < 64; i++) begin
      step();
      if (Led == 8'hFF) ones++;
      if (Led == 8'hFF && prev_led == 8'h00) rises++;
      prev_led = Led;
    end
    check_eq("pwm4_on_cycles", 32'(ones), 32'd16);
    check_eq("pwm4_rises", 32'(rises), 32'd2);

    bus_write(2'd2, 16'h0000);
    step();
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (Led != 8'h00) ones++;
    end
    check_eq("pwm0_dark", 32'(ones), 32'd0);

    // Blink: bit0 toggles every 64 clk, bit1 steady.
    bus_write(2'd3, 16'h0001);
    bus_write(2'd2, 16'h000F);
    bus_write(2'd0, 16'h0003);
    bus_write(2'd1, 16'h0001);
    step();
    wait_bit0_change(200, gap);
    wait_bit0_change(200, gap);
    check_eq("blink_first_seen", 32'(gap <= 200), 32'd1);
    wait_bit0_change(200, gap);
    check_eq("blink_gap_a", 32'(gap), 32'd64);
    wait_bit0_change(200, gap);
    check_eq("blink_gap_b", 32'(gap), 32'd64);
    bit1_low = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (Led[1] !== 1'b1) bit1_low++;
    end
    check_eq("bit1_steady", 32'(bit1_low), 32'd0);

    // Lowering PERIOD below the running count acts on the next wrap.
    bus_write(2'd3, 16'd100);
    read_reg(2'd3, rd);
    check_eq("rd_period", 32'(rd), 32'h0064);
    repeat (100) step();
    bus_write(2'd3, 16'd0);
    wait_bit0_change(40, gap);
    check_eq("period_drop_fast", 32'(gap <= 34), 32'd1);
    wait_bit0_change(100, gap);
    check_eq("period0_gap", 32'(gap), 32'd32);

    // Reset wins over a simultaneous write.
    @(negedge clk);
    reset    = 1'b1;
    bus.we   = 1'b1;
    bus.addr = 2'd0;
    bus.in   = 16'h00FF;
    step();
    reset  = 1'b0;
    bus.we = 1'b0;
    read_reg(2'd0, rd);
    check_eq("rst_we_value", 32'(rd), 32'h0000);
    check_eq("rst_we_led", 32'(Led), 32'h00);
    step();
    check_eq("rst_led_hold", 32'(Led), 32'h00);
    read_reg(2'd2, rd);
    check_eq("rst_duty", 32'(rd), 32'h000F);
    read_reg(2'd3, rd);
    check_eq("rst_period", 32'(rd), 32'h0000);
    read_reg(2'd1, rd);
    check_eq("rst_blink_en", 32'(rd), 32'h0000);
    // Phase resets high: a blink-enabled LED lights straight away.
    bus_write(2'd1, 16'h0001);
    bus_write(2'd0, 16'h0001);
    step();
    check_eq("rst_phase_high", 32'(Led), 32'h01);

    // Oversized write is truncated to NUM_LEDS.
    bus_write(2'd1, 16'h0000);
    bus_write(2'd0, 16'hFFFF);
    read_reg(2'd0, rd);
    check_eq("rd_value_trunc", 32'(rd), 32'h00FF);
    step();
    check_eq("led_all_on", 32'(Led), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
